// File: rtl/hazard_pkg.sv
// Shared opcodes, pipeline control encodings and FSM states for the hazard control unit.
package hazard_pkg;

  localparam logic [4:0] OP_NOP = 5'b00000;
  localparam logic [4:0] OP_BEQ = 5'b00100;

  // Width of each per-register load scoreboard down-counter.
  localparam int SB_CNT_W = 4;

  typedef logic [1:0] pipe_ctl_t;

  localparam pipe_ctl_t CTL_RUN   = 2'b00;
  localparam pipe_ctl_t CTL_NOP   = 2'b01;
  localparam pipe_ctl_t CTL_FLUSH = 2'b01;

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } fsm_t;

endpackage

// File: rtl/hazard_scoreboard.sv
// Per-register in-flight load tracker: one down-counter per register plus a registered busy mask.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W   = 5,
  parameter int LOAD_LATENCY = 1,
  localparam int REG_COUNT   = 2 ** REG_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_en_i,
  input  logic [REG_ADDR_W-1:0] load_rd_i,
  input  logic [REG_ADDR_W-1:0] rs1_i,
  input  logic [REG_ADDR_W-1:0] rs2_i,
  output logic [REG_COUNT-1:0]  busy_mask_o,
  output logic                  rs1_busy_o,
  output logic                  rs2_busy_o
);

  logic [SB_CNT_W-1:0] cnt_q [REG_COUNT];
  logic [SB_CNT_W-1:0] cnt_d [REG_COUNT];
  logic [REG_COUNT-1:0] busy_q;
  logic [REG_COUNT-1:0] busy_d;

  // A new load overrides the decrement, so a re-load restarts the full latency.
  always_comb begin
    for (int r = 0; r < REG_COUNT; r++) begin
      // NOTE: every path assigns cnt_d/busy_d before any condition, so no latch is inferred.
      cnt_d[r] = (cnt_q[r] != '0) ? cnt_q[r] - SB_CNT_W'(1) : '0;
      if (load_en_i && (load_rd_i == REG_ADDR_W'(r))) begin
        cnt_d[r] = SB_CNT_W'(LOAD_LATENCY);
      end
      busy_d[r] = (cnt_d[r] != '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: this array is flops, not a RAM, so it is reset: no register may look pending after reset.
      for (int r = 0; r < REG_COUNT; r++) begin
        cnt_q[r] <= '0;
      end
      busy_q <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every counter update based on the pre-edge values.
      for (int r = 0; r < REG_COUNT; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
      busy_q <= busy_d;
    end
  end

  assign busy_mask_o = busy_q;
  assign rs1_busy_o  = busy_q[rs1_i];
  assign rs2_busy_o  = busy_q[rs2_i];

endmodule

// File: rtl/hazard_control_unit.sv
// Decode-side hazard control: load-use stalls via scoreboard, branch flush sequencing, event counters.
module hazard_control_unit
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W   = 5,
  parameter int DATA_W       = 8,
  parameter int OPCODE_W     = 5,
  parameter int LOAD_LATENCY = 1,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16,
  localparam int REG_COUNT   = 2 ** REG_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [OPCODE_W-1:0]   opcode_decode,
  input  logic [REG_ADDR_W-1:0] rs1_decode,
  input  logic [REG_ADDR_W-1:0] rs2_decode,
  input  logic [REG_ADDR_W-1:0] rd_execute,
  input  logic                  load_execute,
  input  logic [DATA_W-1:0]     regfile_data_1,
  input  logic [DATA_W-1:0]     regfile_data_2,
  output logic [1:0]            nop,
  output logic [1:0]            flush,
  output logic [REG_COUNT-1:0]  busy_mask,
  output logic [CNT_W-1:0]      stall_count,
  output logic [CNT_W-1:0]      flush_count
);

  logic       rs1_busy;
  logic       rs2_busy;
  logic       hz;
  logic       taken;
  logic       start_flush;
  fsm_t       state_q;
  logic [2:0] flen_q;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;

  hazard_scoreboard #(
    .REG_ADDR_W   (REG_ADDR_W),
    .LOAD_LATENCY (LOAD_LATENCY)
  ) u_scoreboard (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_en_i   (load_execute),
    .load_rd_i   (rd_execute),
    .rs1_i       (rs1_decode),
    .rs2_i       (rs2_decode),
    .busy_mask_o (busy_mask),
    .rs1_busy_o  (rs1_busy),
    .rs2_busy_o  (rs2_busy)
  );

  // Same-cycle term catches a load still in execute before the scoreboard has registered it.
  assign hz = rs1_busy | rs2_busy |
              (load_execute & ((rd_execute == rs1_decode) | (rd_execute == rs2_decode)));
  assign taken = (opcode_decode == OPCODE_W'(OP_BEQ)) && (regfile_data_1 == regfile_data_2);

  always_comb begin
    nop         = CTL_RUN;
    flush       = CTL_RUN;
    start_flush = 1'b0;
    if (!rst_n) begin
      nop   = CTL_RUN;
      flush = CTL_RUN;
    end else if (state_q == FLUSH) begin
      flush = CTL_FLUSH;
    end else if (opcode_decode == OPCODE_W'(OP_NOP)) begin
      nop = CTL_RUN;
    end else if (hz) begin
      nop = CTL_NOP;
    end else if (taken) begin
      flush       = CTL_FLUSH;
      start_flush = 1'b1;
    end
  end

  // The first flush cycle is issued from IDLE, so FLUSH covers the remaining FLUSH_CYCLES-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      flen_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_flush && (FLUSH_CYCLES > 1)) begin
            state_q <= FLUSH;
            flen_q  <= 3'(FLUSH_CYCLES - 1);
          end
        end
        FLUSH: begin
          if (flen_q <= 3'd1) begin
            state_q <= IDLE;
            flen_q  <= '0;
          end else begin
            flen_q <= flen_q - 3'd1;
          end
        end
        default: begin
          state_q <= IDLE;
          flen_q  <= '0;
        end
      endcase
    end
  end

  assign stall_d = ((nop == CTL_NOP) && (stall_q != '1)) ? stall_q + CNT_W'(1) : stall_q;
  assign flush_d = ((flush == CTL_FLUSH) && (flush_q != '1)) ? flush_q + CNT_W'(1) : flush_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign stall_count = stall_q;
  assign flush_count = flush_q;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed scoreboard bench: dut_a (latency 1, flush 1, 4-bit counters), dut_b (latency 3, flush 3).
module tb_hazard_control_unit;
  import hazard_pkg::*;

  localparam logic [4:0] OP_ALU = 5'b01100;

  logic        clk;
  logic        rst_a_n, rst_b_n;
  logic [4:0]  opcode_decode, rs1_decode, rs2_decode, rd_execute;
  logic        load_execute;
  logic [7:0]  regfile_data_1, regfile_data_2;

  logic [1:0]  nop_a, flush_a, nop_b, flush_b;
  logic [31:0] busy_a, busy_b;
  logic [3:0]  stall_a, fcnt_a;
  logic [15:0] stall_b, fcnt_b;

  typedef struct {
    string      tag;
    logic [1:0] nop;
    logic [1:0] flush;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   sel_b  = 1'b0;

  hazard_control_unit #(
    .REG_ADDR_W(5), .DATA_W(8), .OPCODE_W(5),
    .LOAD_LATENCY(1), .FLUSH_CYCLES(1), .CNT_W(4)
  ) dut_a (
    .clk(clk), .rst_n(rst_a_n), .opcode_decode(opcode_decode),
    .rs1_decode(rs1_decode), .rs2_decode(rs2_decode), .rd_execute(rd_execute),
    .load_execute(load_execute), .regfile_data_1(regfile_data_1),
    .regfile_data_2(regfile_data_2), .nop(nop_a), .flush(flush_a),
    .busy_mask(busy_a), .stall_count(stall_a), .flush_count(fcnt_a)
  );

  hazard_control_unit #(
    .REG_ADDR_W(5), .DATA_W(8), .OPCODE_W(5),
    .LOAD_LATENCY(3), .FLUSH_CYCLES(3), .CNT_W(16)
  ) dut_b (
    .clk(clk), .rst_n(rst_b_n), .opcode_decode(opcode_decode),
    .rs1_decode(rs1_decode), .rs2_decode(rs2_decode), .rd_execute(rd_execute),
    .load_execute(load_execute), .regfile_data_1(regfile_data_1),
    .regfile_data_2(regfile_data_2), .nop(nop_b), .flush(flush_b),
    .busy_mask(busy_b), .stall_count(stall_b), .flush_count(fcnt_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish, required finish before time limit");
    $fatal(1, "time limit expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one decode cycle, queue its expected controls, compare on the falling edge.
  task automatic step(input logic [4:0] op, input logic [4:0] r1, input logic [4:0] r2,
                      input logic [4:0] rd, input logic ld, input logic [7:0] d1,
                      input logic [7:0] d2, input logic [1:0] enop, input logic [1:0] eflush,
                      input string tag);
    exp_t e;
    opcode_decode  = op;
    rs1_decode     = r1;
    rs2_decode     = r2;
    rd_execute     = rd;
    load_execute   = ld;
    regfile_data_1 = d1;
    regfile_data_2 = d2;
    sb_q.push_back('{tag: tag, nop: enop, flush: eflush});
    @(negedge clk);
    e = sb_q.pop_front();
    check({e.tag, "_nop"},   32'(sel_b ? nop_b   : nop_a),   32'(e.nop));
    check({e.tag, "_flush"}, 32'(sel_b ? flush_b : flush_a), 32'(e.flush));
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset with a same-cycle load-use pattern on the inputs: controls must stay quiet.
    rst_a_n = 1'b0; rst_b_n = 1'b0;
    opcode_decode = OP_ALU; rs1_decode = 5'd3; rs2_decode = 5'd0; rd_execute = 5'd3;
    load_execute = 1'b1; regfile_data_1 = 8'h00; regfile_data_2 = 8'h00;
    #1;
    check("rst_nop_a", 32'(nop_a), 32'(CTL_RUN));
    check("rst_flush_a", 32'(flush_a), 32'(CTL_RUN));
    check("rst_nop_b", 32'(nop_b), 32'(CTL_RUN));
    check("rst_busy_a", busy_a, 32'h0);
    check("rst_stall_b", 32'(stall_b), 32'h0);
    check("rst_fcnt_b", 32'(fcnt_b), 32'h0);
    @(posedge clk);
    #1;
    rst_a_n = 1'b1;

    // dut_a, LOAD_LATENCY = 1: same-cycle stall, then decode moves on to an independent register.
    sel_b = 1'b0;
    step(OP_ALU, 5'd3, 5'd0, 5'd3, 1'b1, 8'h00, 8'h00, CTL_NOP, CTL_RUN, "a_ll1_c0");
    check("a_ll1_busy_c0", busy_a, 32'h0000_0008);
    step(OP_ALU, 5'd7, 5'd8, 5'd0, 1'b0, 8'h00, 8'h00, CTL_RUN, CTL_RUN, "a_ll1_c1");
    check("a_ll1_busy_c1", busy_a, 32'h0);
    check("a_ll1_stall", 32'(stall_a), 32'd1);

    // dut_a, FLUSH_CYCLES = 1: continuous taken BEQs pulse flush every cycle; 4-bit counter saturates.
    for (int i = 0; i < 21; i++) begin
      step(OP_BEQ, 5'd1, 5'd2, 5'd0, 1'b0, 8'h2A, 8'h2A, CTL_RUN, CTL_FLUSH, "a_sat");
    end
    check("a_fcnt_sat", 32'(fcnt_a), 32'h0000_000F);
    check("a_stall_hold", 32'(stall_a), 32'd1);

    // dut_b, LOAD_LATENCY = 3: load r5 then decode reads r5 for cycles 0..4.
    sel_b = 1'b1;
    rst_b_n = 1'b1;
    step(OP_ALU, 5'd5, 5'd0, 5'd5, 1'b1, 8'h00, 8'h00, CTL_NOP, CTL_RUN, "b_ll3_c0");
    check("b_ll3_busy_c0", busy_b, 32'h0000_0020);
    for (int i = 1; i <= 3; i++) begin
      step(OP_ALU, 5'd5, 5'd0, 5'd0, 1'b0, 8'h00, 8'h00, CTL_NOP, CTL_RUN, "b_ll3_cn");
    end
    step(OP_ALU, 5'd5, 5'd0, 5'd0, 1'b0, 8'h00, 8'h00, CTL_RUN, CTL_RUN, "b_ll3_c4");
    check("b_ll3_busy_c4", busy_b, 32'h0);
    check("b_ll3_stall", 32'(stall_b), 32'd4);

    // Re-load r5 one cycle later: pending window restarts at 3.
    step(OP_ALU, 5'd9, 5'd9, 5'd5, 1'b1, 8'h00, 8'h00, CTL_RUN, CTL_RUN, "b_rl_c0");
    step(OP_ALU, 5'd9, 5'd9, 5'd5, 1'b1, 8'h00, 8'h00, CTL_RUN, CTL_RUN, "b_rl_c1");
    for (int i = 2; i <= 3; i++) begin
      step(OP_ALU, 5'd9, 5'd9, 5'd0, 1'b0, 8'h00, 8'h00, CTL_RUN, CTL_RUN, "b_rl_cn");
    end
    check("b_rl_busy_c3", busy_b, 32'h0000_0020);
    step(OP_ALU, 5'd9, 5'd9, 5'd0, 1'b0, 8'h00, 8'h00, CTL_RUN, CTL_RUN, "b_rl_c4");
    check("b_rl_busy_c4", busy_b, 32'h0);

    // Taken BEQ, FLUSH_CYCLES = 3; a second taken BEQ during FLUSH must not extend it.
    for (int i = 0; i < 3; i++) begin
      step(OP_BEQ, 5'd1, 5'd2, 5'd0, 1'b0, 8'h2A, 8'h2A, CTL_RUN, CTL_FLUSH, "b_beq_fl");
    end
    step(OP_ALU, 5'd1, 5'd2, 5'd0, 1'b0, 8'h2A, 8'h2A, CTL_RUN, CTL_RUN, "b_beq_end");
    check("b_beq_fcnt", 32'(fcnt_b), 32'd3);

    // Unequal operands: not taken.
    step(OP_BEQ, 5'd1, 5'd2, 5'd0, 1'b0, 8'h2A, 8'h2B, CTL_RUN, CTL_RUN, "b_beq_ne");

    // BEQ whose rs2 is pending: stall until clear, then flush; hazards ignored while flushing.
    step(OP_ALU, 5'd9, 5'd9, 5'd6, 1'b1, 8'h00, 8'h00, CTL_RUN, CTL_RUN, "b_pend_ld");
    for (int i = 1; i <= 3; i++) begin
      step(OP_BEQ, 5'd1, 5'd6, 5'd0, 1'b0, 8'h2A, 8'h2A, CTL_NOP, CTL_RUN, "b_pend_stall");
    end
    step(OP_BEQ, 5'd1, 5'd6, 5'd0, 1'b0, 8'h2A, 8'h2A, CTL_RUN, CTL_FLUSH, "b_pend_take");
    step(OP_ALU, 5'd4, 5'd0, 5'd4, 1'b1, 8'h00, 8'h00, CTL_RUN, CTL_FLUSH, "b_fl_ign_same");
    step(OP_ALU, 5'd4, 5'd0, 5'd0, 1'b0, 8'h00, 8'h00, CTL_RUN, CTL_FLUSH, "b_fl_ign_busy");
    step(OP_ALU, 5'd4, 5'd0, 5'd0, 1'b0, 8'h00, 8'h00, CTL_NOP, CTL_RUN, "b_post_fl_hz");

    // OP_NOP reading a pending register never stalls.
    step(OP_NOP, 5'd4, 5'd4, 5'd0, 1'b0, 8'h00, 8'h00, CTL_RUN, CTL_RUN, "b_opnop");
    check("b_stall_total", 32'(stall_b), 32'd8);
    check("b_fcnt_total", 32'(fcnt_b), 32'd6);

    // Asynchronous reset in the middle of FLUSH with r7 pending.
    step(OP_ALU, 5'd9, 5'd9, 5'd7, 1'b1, 8'h00, 8'h00, CTL_RUN, CTL_RUN, "b_mid_ld");
    step(OP_BEQ, 5'd1, 5'd2, 5'd0, 1'b0, 8'h2A, 8'h2A, CTL_RUN, CTL_FLUSH, "b_mid_take");
    check("b_mid_busy", busy_b, 32'h0000_0080);
    opcode_decode = OP_ALU; rs1_decode = 5'd9; rs2_decode = 5'd9; load_execute = 1'b0;
    rst_b_n = 1'b0;
    #1;
    check("b_arst_flush", 32'(flush_b), 32'(CTL_RUN));
    check("b_arst_nop", 32'(nop_b), 32'(CTL_RUN));
    check("b_arst_busy", busy_b, 32'h0);
    check("b_arst_stall", 32'(stall_b), 32'h0);
    check("b_arst_fcnt", 32'(fcnt_b), 32'h0);
    @(negedge clk);
    rst_b_n = 1'b1;
    @(posedge clk);
    #1;
    step(OP_ALU, 5'd7, 5'd7, 5'd0, 1'b0, 8'h00, 8'h00, CTL_RUN, CTL_RUN, "b_post_rst");
    check("b_post_rst_busy", busy_b, 32'h0);
    check("b_post_rst_fcnt", 32'(fcnt_b), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
